viterbi_frame_sequencer: RTL and testbench
==========================================

# viterbi_frame_sequencer

Frame-level controller for the receiver's Viterbi decoder core. It takes the serial, deinterleaved coded-bit stream, groups it into rate-1/2 bit pairs, and issues one ACS step per pair with a step index. At frame end it starts the core's traceback and waits for completion under a watchdog, then clears the core's path metrics before the next frame. It sits between the deinterleaver output and the Viterbi core, and reports frame status to the receiver top level.

## Interface
- PAIRS, 96: coded-bit pairs per frame (trellis steps); range 2..255.
- TB_TIMEOUT, 1023: maximum cycles spent in TRACE waiting for CoreTbDone; range 1..1023.

- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InBit  in  1  coded bit.
- InValid  in  1  InBit is valid this cycle.
- FrameStart  in  1  qualified by InValid; marks the first coded bit of a frame.
- CoreBitA  out  1  first bit of the pair, which is the earlier bit received.
- CoreBitB  out  1  second bit of the pair.
- CoreStep  out  1  one-cycle strobe: CoreBitA, CoreBitB and CoreStepIndex are valid.
- CoreFirst  out  1  high with the CoreStep of pair 0.
- CoreStepIndex  out  8  pair index 0..PAIRS-1.
- CoreTbStart  out  1  one-cycle traceback start strobe.
- CoreTbDone  in  1  traceback complete; level or pulse.
- CoreClear  out  1  one-cycle strobe that reinitialises the core's metrics and paths.
- Busy  out  1  high when the FSM is not in IDLE.
- FrameDone  out  1  one-cycle strobe: frame decoded successfully.
- Timeout  out  1  one-cycle strobe: the traceback watchdog expired.
- Overrun  out  1  sticky flag: input arrived while it could not be accepted.

## Operation
- All outputs are registered. At Reset every output is 0, the FSM is in CLEAR, and all counters and the half-pair flag are 0.
- FSM states: CLEAR, IDLE, COLLECT, TRACE.
- **CLEAR**
  - Assert CoreClear for exactly one cycle, then go to IDLE.
  - Any InValid in this state sets Overrun.
- **IDLE**
  - InValid without FrameStart: the bit is discarded and no flag is set.
  - InValid with FrameStart:
    - capture InBit as the pending A bit;
    - set half=1, pair count=0, clear Overrun;
    - go to COLLECT.
- **COLLECT**, for each InValid:
  - If half=0: capture the bit as pending A and set half=1.
  - If half=1, on the next cycle:
    - drive CoreBitA=pending A and CoreBitB=InBit;
    - drive CoreStepIndex=count and CoreFirst=(count==0);
    - pulse CoreStep;
    - then set count+1 and half=0.
  - When the step with index PAIRS-1 is issued, go to TRACE.
  - FrameStart with InValid in COLLECT aborts the frame:
    - pulse CoreClear on the next cycle;
    - count=0; the bit becomes the new pending A with half=1;
    - stay in COLLECT; no FrameDone, no Overrun.
    - Because a pair needs a second bit, CoreClear always precedes the new frame's first CoreStep.
- **TRACE**
  - On entry, pulse CoreTbStart for one cycle and set the watchdog to 0.
  - The watchdog increments each cycle.
  - CoreTbDone=1 before the watchdog reaches TB_TIMEOUT: pulse FrameDone, then go to CLEAR.
  - Watchdog reaches TB_TIMEOUT with CoreTbDone still 0: pulse Timeout and go to CLEAR; no FrameDone.
  - Any InValid in TRACE sets Overrun; the bit is dropped.
- CoreTbDone is ignored outside TRACE.
- Overrun stays high until the next accepted FrameStart in IDLE, or until Reset.
- Arithmetic:
  - count is 8-bit and never exceeds PAIRS-1 on the outputs;
  - the watchdog is 10-bit and saturates, with no wrap-around.
- Reset asserted in any state returns to CLEAR immediately: outputs go to 0 and the pending bit is lost. After Reset deasserts, one CoreClear pulse is issued.

## Timing
- Second bit of a pair sampled at edge t: CoreStep is high during the cycle after edge t, and never for more than one cycle.
- Last CoreStep (index PAIRS-1) in cycle k: CoreTbStart is in cycle k+1.
- CoreTbDone sampled at edge t: FrameDone is high in the cycle after edge t; CoreClear is in the next cycle; IDLE follows one cycle later.
- CoreTbDone sampled on the first TRACE edge is accepted, giving a minimum traceback of 1 cycle.
- Timeout is issued TB_TIMEOUT cycles after CoreTbStart, followed by CoreClear on the next cycle.
- Back-to-back pairs are possible on consecutive cycles: with InValid continuously high, CoreStep fires every 2nd cycle.
- Turnaround is CLEAR + IDLE = 2 cycles, plus traceback time. The upstream block must hold off the next frame until Busy=0.

## Test plan
- Reset, then PAIRS=4 with 8 continuous bits 1,1,0,1,0,0,1,0:
  - CoreClear once after reset;
  - steps (A,B,idx) = (1,1,0) with CoreFirst, then (0,1,1), (0,0,2), (1,0,3);
  - CoreTbStart one cycle after the idx-3 step;
  - CoreTbDone 5 cycles later, then FrameDone, CoreClear, and Busy=0.
- Gapped input with InValid every 3rd cycle: the same pairs and indices are produced; CoreStep only follows a second bit.
- CoreTbDone held at 0, TB_TIMEOUT=8:
  - Timeout exactly 8 cycles after CoreTbStart, then CoreClear;
  - FrameDone never asserted.
- FrameStart re-asserted after 3 bits (half=1, count=1):
  - CoreClear next cycle;
  - the next CoreStep has idx 0 with CoreFirst, and its A bit is the FrameStart bit.
- InValid pulses during TRACE and CLEAR: Overrun=1 and no extra CoreStep. Overrun stays 1 until the next IDLE FrameStart clears it.
- Reset asserted mid-COLLECT (count=2): outputs are 0 immediately; after deassertion, one CoreClear, and the next frame starts at idx 0.

Source files
------------

// File: rtl/viterbi_frame_sequencer.sv
// rtl/viterbi_frame_sequencer.sv - pairs coded bits into ACS steps and sequences traceback/clear per frame
module viterbi_frame_sequencer #(
  parameter int PAIRS      = 96,
  parameter int TB_TIMEOUT = 1023
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InBit,
  input  logic       InValid,
  input  logic       FrameStart,
  output logic       CoreBitA,
  output logic       CoreBitB,
  output logic       CoreStep,
  output logic       CoreFirst,
  output logic [7:0] CoreStepIndex,
  output logic       CoreTbStart,
  input  logic       CoreTbDone,
  output logic       CoreClear,
  output logic       Busy,
  output logic       FrameDone,
  output logic       Timeout,
  output logic       Overrun
);

  typedef enum logic [1:0] {CLEAR, IDLE, COLLECT, TRACE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAIRS - 1);
  localparam logic [9:0] WD_LIMIT = 10'(TB_TIMEOUT);

  state_t     state, state_next;
  logic       pend_a, pend_a_next;
  logic       half, half_next;
  logic [7:0] count, count_next;
  logic [9:0] wd, wd_next;

  logic       bit_a_next, bit_b_next, step_next, first_next;
  logic [7:0] index_next;
  logic       tb_start_next, clear_next, busy_next, done_next, timeout_next, overrun_next;

  logic       frame_in, pair_in;
  assign frame_in = InValid && FrameStart;
  assign pair_in  = InValid && !FrameStart && half;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= CLEAR;
      pend_a        <= 1'b0;
      half          <= 1'b0;
      count         <= 8'd0;
      wd            <= 10'd0;
      CoreBitA      <= 1'b0;
      CoreBitB      <= 1'b0;
      CoreStep      <= 1'b0;
      CoreFirst     <= 1'b0;
      CoreStepIndex <= 8'd0;
      CoreTbStart   <= 1'b0;
      CoreClear     <= 1'b0;
      Busy          <= 1'b0;
      FrameDone     <= 1'b0;
      Timeout       <= 1'b0;
      Overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      pend_a        <= pend_a_next;
      half          <= half_next;
      count         <= count_next;
      wd            <= wd_next;
      CoreBitA      <= bit_a_next;
      CoreBitB      <= bit_b_next;
      CoreStep      <= step_next;
      CoreFirst     <= first_next;
      CoreStepIndex <= index_next;
      CoreTbStart   <= tb_start_next;
      CoreClear     <= clear_next;
      Busy          <= busy_next;
      FrameDone     <= done_next;
      Timeout       <= timeout_next;
      Overrun       <= overrun_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   state_next = IDLE;
      IDLE:    if (frame_in) state_next = COLLECT;
      COLLECT: if (pair_in && count == LAST_IDX) state_next = TRACE;
      TRACE:   if (CoreTbDone || wd == WD_LIMIT) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Busy lags the state by one cycle, so it stays high through the final CoreClear pulse.
  always_comb begin
    pend_a_next   = pend_a;
    half_next     = half;
    count_next    = count;
    wd_next       = 10'd0;
    bit_a_next    = CoreBitA;
    bit_b_next    = CoreBitB;
    index_next    = CoreStepIndex;
    step_next     = 1'b0;
    first_next    = 1'b0;
    tb_start_next = 1'b0;
    clear_next    = 1'b0;
    done_next     = 1'b0;
    timeout_next  = 1'b0;
    overrun_next  = Overrun;
    busy_next     = (state != IDLE);
    case (state)
      CLEAR: begin
        clear_next = 1'b1;
        if (InValid) overrun_next = 1'b1;
      end
      IDLE: begin
        if (frame_in) begin
          pend_a_next  = InBit;
          half_next    = 1'b1;
          count_next   = 8'd0;
          overrun_next = 1'b0;
        end
      end
      COLLECT: begin
        if (frame_in) begin
          clear_next  = 1'b1;
          count_next  = 8'd0;
          pend_a_next = InBit;
          half_next   = 1'b1;
        end else if (InValid && !half) begin
          pend_a_next = InBit;
          half_next   = 1'b1;
        end else if (pair_in) begin
          bit_a_next = pend_a;
          bit_b_next = InBit;
          index_next = count;
          first_next = (count == 8'd0);
          step_next  = 1'b1;
          count_next = (count == LAST_IDX) ? 8'd0 : count + 8'd1;
          half_next  = 1'b0;
        end
      end
      TRACE: begin
        // The watchdog is forced to zero outside TRACE, so zero marks the first TRACE cycle.
        tb_start_next = (wd == 10'd0);
        wd_next       = (wd == 10'h3ff) ? wd : wd + 10'd1;
        if (InValid) overrun_next = 1'b1;
        if (CoreTbDone) done_next = 1'b1;
        else if (wd == WD_LIMIT) timeout_next = 1'b1;
      end
      default: clear_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// tb/tb_viterbi_frame_sequencer.sv - randomized self-checking bench for viterbi_frame_sequencer
module tb_viterbi_frame_sequencer;
  localparam int PAIRS      = 4;
  localparam int TB_TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0, in_valid = 1'b0, frame_start = 1'b0, core_tb_done = 1'b0;
  logic       core_bit_a, core_bit_b, core_step, core_first, core_tb_start, core_clear;
  logic       busy, frame_done, timeout, overrun;
  logic [7:0] core_step_index;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit exp_ovr = 1'b0;

  typedef struct packed {
    int         cyc;
    logic       a;
    logic       b;
    logic       first;
    logic [7:0] idx;
  } step_t;

  step_t obs_step[$];
  int    obs_tbs[$], obs_done[$], obs_to[$], obs_clr[$];

  viterbi_frame_sequencer #(.PAIRS(PAIRS), .TB_TIMEOUT(TB_TIMEOUT)) dut (
    .Clock(clock), .Reset(reset), .InBit(in_bit), .InValid(in_valid), .FrameStart(frame_start),
    .CoreBitA(core_bit_a), .CoreBitB(core_bit_b), .CoreStep(core_step), .CoreFirst(core_first),
    .CoreStepIndex(core_step_index), .CoreTbStart(core_tb_start), .CoreTbDone(core_tb_done),
    .CoreClear(core_clear), .Busy(busy), .FrameDone(frame_done), .Timeout(timeout), .Overrun(overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (core_step) obs_step.push_back('{cyc, core_bit_a, core_bit_b, core_first, core_step_index});
      if (core_tb_start) obs_tbs.push_back(cyc);
      if (frame_done) obs_done.push_back(cyc);
      if (timeout) obs_to.push_back(cyc);
      if (core_clear) obs_clr.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit got=expired want=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int want[$]);
    check_eq({tag, "_n"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      check_eq($sformatf("%s%0d", tag, i), got[i], want[i]);
  endtask

  // Inputs set here are sampled on the next rising edge; returns at the following falling edge.
  task automatic slot(input logic v, input logic b, input logic fs, input logic d);
    in_valid = v; in_bit = b; frame_start = fs; core_tb_done = d;
    @(negedge clock);
  endtask

  task automatic clear_obs();
    obs_step.delete(); obs_tbs.delete(); obs_done.delete(); obs_to.delete(); obs_clr.delete();
  endtask

  task automatic apply_reset();
    int rst_cyc;
    #2 reset = 1'b1;
    in_valid = 1'b0; frame_start = 1'b0; core_tb_done = 1'b0;
    #1 check_eq("reset_outputs", {core_bit_a, core_bit_b, core_step, core_first, core_step_index,
                                  core_tb_start, core_clear, busy, frame_done, timeout, overrun}, 64'd0);
    repeat (2) @(negedge clock);
    clear_obs();
    reset = 1'b0;
    rst_cyc = cyc;
    repeat (3) slot(1'b0, 1'b0, 1'b0, 1'b0);
    check_q("post_reset_clear", obs_clr, '{rst_cyc + 1});
    check_eq("post_reset_steps", obs_step.size(), 0);
    check_eq("post_reset_busy", busy, 1'b0);
    exp_ovr = 1'b0;
  endtask

  task automatic run_frame(input int gap_mode, input int abort_at, input bit use_to, input bit inject,
                           input int j_fixed, input bit fixed_en, input logic [7:0] fixed_bits);
    logic  bits_q[$];
    int    edges_q[$];
    bit    fs_q[$];
    step_t exp_step[$];
    int    exp_clr[$], exp_done[$], exp_to[$];
    int    n, gap, seg_start, c, j, e_done, last_e, e;
    logic  b, v, d;
    clear_obs();
    if ($urandom_range(0, 1) == 1) begin
      slot(1'b1, 1'($urandom), 1'b0, 1'b0);
      check_eq("idle_junk_overrun", overrun, exp_ovr);
    end
    n = abort_at + 2 * PAIRS;
    for (int k = 0; k < n; k++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      repeat (gap) slot(1'b0, 1'($urandom), 1'b0, 1'b0);
      b = (fixed_en && abort_at == 0) ? fixed_bits[7 - k] : 1'($urandom);
      slot(1'b1, b, (k == 0) || (abort_at > 0 && k == abort_at), 1'b0);
      bits_q.push_back(b);
      edges_q.push_back(cyc);
      fs_q.push_back((k == 0) || (abort_at > 0 && k == abort_at));
      if (k == 0) check_eq("start_clears_overrun", overrun, 1'b0);
    end
    // Reference: bits after each frame start group into pairs; a restart costs one clear.
    seg_start = 0;
    for (int i = 0; i < n; i++) begin
      if (fs_q[i]) begin
        seg_start = i;
        if (i > 0) exp_clr.push_back(edges_q[i]);
      end else if ((i - seg_start) % 2 == 1) begin
        exp_step.push_back('{edges_q[i], bits_q[i - 1], bits_q[i], (i - seg_start) == 1, 8'((i - seg_start) / 2)});
      end
    end
    c = edges_q[n - 1] + 1;
    e_done = 0;
    if (use_to) begin
      last_e = c + TB_TIMEOUT + 1;
      exp_to.push_back(c + TB_TIMEOUT);
    end else begin
      j = (j_fixed >= 0) ? j_fixed : int'($urandom_range(0, TB_TIMEOUT - 1));
      e_done = c + j;
      last_e = e_done + 1;
      exp_done.push_back(e_done);
    end
    exp_clr.push_back(last_e);
    while (cyc + 1 <= last_e) begin
      e = cyc + 1;
      v = inject && (e == c || $urandom_range(0, 1) == 1);
      d = !use_to && (e >= e_done);
      slot(v, 1'($urandom), 1'b0, d);
    end
    check_eq("busy_during_clear", busy, 1'b1);
    slot(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("busy_after_frame", busy, 1'b0);
    slot(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("steps_n", obs_step.size(), exp_step.size());
    for (int i = 0; i < obs_step.size() && i < exp_step.size(); i++)
      check_eq($sformatf("step%0d", i), obs_step[i], exp_step[i]);
    check_q("tbstart", obs_tbs, '{c});
    check_q("framedone", obs_done, exp_done);
    check_q("timeout", obs_to, exp_to);
    check_q("clear", obs_clr, exp_clr);
    exp_ovr = inject;
    check_eq("overrun", overrun, exp_ovr);
  endtask

  initial begin
    apply_reset();
    run_frame(0, 0, 1'b0, 1'b0, 5, 1'b1, 8'b1101_0010);
    run_frame(1, 0, 1'b0, 1'b0, -1, 1'b1, 8'b1101_0010);
    run_frame(0, 0, 1'b1, 1'b0, -1, 1'b0, 8'd0);
    run_frame(0, 3, 1'b0, 1'b0, -1, 1'b0, 8'd0);
    run_frame(2, 0, 1'b0, 1'b1, -1, 1'b0, 8'd0);
    run_frame(0, 0, 1'b0, 1'b0, 0, 1'b0, 8'd0);
    clear_obs();
    slot(1'b1, 1'($urandom), 1'b1, 1'b0);
    repeat (4) slot(1'b1, 1'($urandom), 1'b0, 1'b0);
    check_eq("mid_collect_steps", obs_step.size(), 2);
    apply_reset();
    run_frame(0, 0, 1'b0, 1'b0, -1, 1'b0, 8'd0);
    for (int it = 0; it < 8; it++)
      run_frame(int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 6)),
                $urandom_range(0, 3) == 0, 1'($urandom), -1, 1'b0, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
